// File: rtl/softmax_if.sv
// softmax_if: bundles the softmax stage's handshake and alpha-BRAM write bus.
//   slave  modport: the softmax unit (takes coefficients, drives the BRAM port).
//   master modport: the upstream/controller side.
// Signals:
//   dmvm_ready_i     - one-cycle pulse, coef_i/num_of_nodes_i valid
//   coef_i           - ReLU'd coefficient vector, NUM_OF_NODES entries
//   num_of_nodes_i   - node count of the sub-graph
//   softmax_idle_o   - high while a new sub-graph can be accepted
//   alpha_BRAM_*     - alpha BRAM write port (ena, wea, addra, din)
//   softmax_ready_o  - one-cycle pulse once all alphas of a sub-graph are written
//   drop_err_o       - sticky: a sub-graph arrived while busy and was dropped
interface softmax_if #(
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_OF_NODES    = 168,
   parameter int NUM_NODE_WIDTH  = $clog2(NUM_OF_NODES),
   parameter int BRAM_ADDR_WIDTH = 32
);
   logic                       dmvm_ready_i;
   logic [DATA_WIDTH-1:0]      coef_i [NUM_OF_NODES];
   logic [NUM_NODE_WIDTH:0]    num_of_nodes_i;
   logic                       softmax_idle_o;
   logic                       alpha_BRAM_ena;
   logic                       alpha_BRAM_wea;
   logic [BRAM_ADDR_WIDTH-1:0] alpha_BRAM_addra;
   logic [DATA_WIDTH-1:0]      alpha_BRAM_din;
   logic                       softmax_ready_o;
   logic                       drop_err_o;

   modport master (
      output dmvm_ready_i, coef_i, num_of_nodes_i,
      input  softmax_idle_o, alpha_BRAM_ena, alpha_BRAM_wea, alpha_BRAM_addra,
             alpha_BRAM_din, softmax_ready_o, drop_err_o
   );

   modport slave (
      input  dmvm_ready_i, coef_i, num_of_nodes_i,
      output softmax_idle_o, alpha_BRAM_ena, alpha_BRAM_wea, alpha_BRAM_addra,
             alpha_BRAM_din, softmax_ready_o, drop_err_o
   );
endinterface

// File: rtl/softmax_unit.sv
// softmax_unit: serial fixed-point softmax over one sub-graph's attention
// coefficients. Captures the coefficient vector on dmvm_ready_i, finds the
// maximum, builds a shift-based exp approximation per node, then divides each
// exp term by the sum with one shared restoring divider and writes the
// resulting Q0.DATA_WIDTH alpha into the alpha BRAM, one node at a time.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - softmax_if slave modport (capture handshake, BRAM write port,
//           completion pulse, idle and sticky drop-error flags)
module softmax_unit #(
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_OF_NODES    = 168,
   parameter int NUM_NODE_WIDTH  = $clog2(NUM_OF_NODES),
   parameter int EXP_SHIFT       = 2,
   parameter int BRAM_ADDR_WIDTH = 32,
   parameter int ALPHA_DEPTH     = 4096,
   parameter int SUM_WIDTH       = DATA_WIDTH + NUM_NODE_WIDTH
) (
   input  logic     clk,
   input  logic     rst_n,
   softmax_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [DATA_WIDTH-1:0]      MAX_VALUE = '1;
   localparam logic [DATA_WIDTH-1:0]      DW_LIMIT  = DATA_WIDTH'(DATA_WIDTH);
   localparam logic [NUM_NODE_WIDTH:0]    N_MAX     = (NUM_NODE_WIDTH+1)'(NUM_OF_NODES);
   localparam logic [BRAM_ADDR_WIDTH-1:0] PTR_LAST  = BRAM_ADDR_WIDTH'(ALPHA_DEPTH - 1);
   localparam logic [CNT_W-1:0]           DIV_LAST  = CNT_W'(DATA_WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_MAX, S_EXP, S_DIV, S_WRITE, S_DONE} state_t;

   state_t                     state_q;
   logic [NUM_NODE_WIDTH:0]    n_q;
   logic [NUM_NODE_WIDTH-1:0]  idx_q;
   logic [DATA_WIDTH-1:0]      max_q;
   logic [SUM_WIDTH-1:0]       sum_q;
   logic [SUM_WIDTH:0]         rem_q;
   logic [DATA_WIDTH:0]        quo_q;
   logic [CNT_W-1:0]           cnt_q;
   logic [BRAM_ADDR_WIDTH-1:0] ptr_q;
   logic [DATA_WIDTH-1:0]      coef_q [NUM_OF_NODES];
   logic [DATA_WIDTH-1:0]      e_q    [NUM_OF_NODES];

   logic                       idle_q;
   logic                       ena_q;
   logic                       wea_q;
   logic [BRAM_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]      din_q;
   logic                       ready_q;
   logic                       drop_q;

   logic                       capture;
   logic [NUM_NODE_WIDTH:0]    n_clamped;
   logic                       last_idx;
   logic [NUM_NODE_WIDTH-1:0]  idx_inc;
   logic [DATA_WIDTH-1:0]      coef_cur;
   logic [DATA_WIDTH-1:0]      shift_d;
   logic [DATA_WIDTH-1:0]      e_cur;
   logic                       rem_ge;
   logic [SUM_WIDTH:0]         rem_sub;
   logic [DATA_WIDTH:0]        quo_next;
   logic [DATA_WIDTH-1:0]      alpha;

   assign capture   = bus.dmvm_ready_i && (state_q == S_IDLE);
   assign n_clamped = (bus.num_of_nodes_i > N_MAX) ? N_MAX : bus.num_of_nodes_i;
   // n_q is at least 1 whenever this is used, and n_q-1 always fits an index
   assign last_idx  = (idx_q == NUM_NODE_WIDTH'(n_q - 1'b1));
   assign idx_inc   = idx_q + 1'b1;
   assign coef_cur  = coef_q[idx_q];

   // Shift-based exp: every EXP_SHIFT-scaled unit below the max halves the term
   assign shift_d   = (max_q - coef_cur) >> EXP_SHIFT;
   assign e_cur     = (shift_d >= DW_LIMIT) ? '0 : (MAX_VALUE >> shift_d);

   // One restoring step per cycle; quotient bits emerge MSB (weight 2^DATA_WIDTH) first
   assign rem_ge    = (rem_q >= {1'b0, sum_q});
   assign rem_sub   = rem_ge ? (rem_q - {1'b0, sum_q}) : rem_q;
   assign quo_next  = {quo_q[DATA_WIDTH-1:0], rem_ge};
   assign alpha     = quo_next[DATA_WIDTH] ? MAX_VALUE : quo_next[DATA_WIDTH-1:0];

   // Per-element coefficient capture and exp-term storage
   for (genvar gi = 0; gi < NUM_OF_NODES; gi++) begin : g_elem
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            coef_q[gi] <= '0;
         end else if (capture) begin
            coef_q[gi] <= bus.coef_i[gi];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            e_q[gi] <= '0;
         end else if (state_q == S_EXP && idx_q == NUM_NODE_WIDTH'(gi)) begin
            e_q[gi] <= e_cur;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         max_q   <= '0;
         sum_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         idle_q  <= 1'b1;
         ena_q   <= 1'b0;
         wea_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         ready_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         if (bus.dmvm_ready_i && state_q != S_IDLE) begin
            drop_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (bus.dmvm_ready_i) begin
                  n_q    <= n_clamped;
                  idx_q  <= '0;
                  max_q  <= '0;
                  sum_q  <= '0;
                  idle_q <= 1'b0;
                  if (n_clamped == '0) begin
                     ready_q <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_MAX;
                  end
               end
            end

            S_MAX: begin
               if (coef_cur > max_q) begin
                  max_q <= coef_cur;
               end
               if (last_idx) begin
                  idx_q   <= '0;
                  state_q <= S_EXP;
               end else begin
                  idx_q <= idx_inc;
               end
            end

            S_EXP: begin
               sum_q <= sum_q + SUM_WIDTH'(e_cur);
               if (last_idx) begin
                  // e_q[0] is only being written now when n=1, so bypass it then
                  rem_q   <= (idx_q == '0) ? (SUM_WIDTH+1)'(e_cur) : (SUM_WIDTH+1)'(e_q[0]);
                  quo_q   <= '0;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  state_q <= S_DIV;
               end else begin
                  idx_q <= idx_inc;
               end
            end

            S_DIV: begin
               rem_q <= rem_sub << 1;
               quo_q <= quo_next;
               if (cnt_q == DIV_LAST) begin
                  ena_q   <= 1'b1;
                  wea_q   <= 1'b1;
                  addr_q  <= ptr_q;
                  din_q   <= alpha;
                  state_q <= S_WRITE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_WRITE: begin
               ena_q <= 1'b0;
               wea_q <= 1'b0;
               ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
               if (last_idx) begin
                  ready_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_inc;
                  rem_q   <= (SUM_WIDTH+1)'(e_q[idx_inc]);
                  quo_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_DIV;
               end
            end

            S_DONE: begin
               ready_q <= 1'b0;
               idle_q  <= 1'b1;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.softmax_idle_o   = idle_q;
   assign bus.alpha_BRAM_ena   = ena_q;
   assign bus.alpha_BRAM_wea   = wea_q;
   assign bus.alpha_BRAM_addra = addr_q;
   assign bus.alpha_BRAM_din   = din_q;
   assign bus.softmax_ready_o  = ready_q;
   assign bus.drop_err_o       = drop_q;

endmodule

// File: tb/tb_softmax_unit.sv
// tb_softmax_unit: directed vectors for softmax_unit with hand-computed alphas.
// The DUT runs with ALPHA_DEPTH=4 so pointer wrap is exercised by ordinary
// traffic; the bench tracks the expected write address itself.
`timescale 1ns/1ps
module tb_softmax_unit;
   localparam int DW    = 8;
   localparam int NN    = 168;
   localparam int NW    = $clog2(NN);
   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   softmax_if #(.DATA_WIDTH(DW), .NUM_OF_NODES(NN), .NUM_NODE_WIDTH(NW),
                .BRAM_ADDR_WIDTH(AW)) bus ();

   softmax_unit #(.DATA_WIDTH(DW), .NUM_OF_NODES(NN), .NUM_NODE_WIDTH(NW),
                  .EXP_SHIFT(2), .BRAM_ADDR_WIDTH(AW), .ALPHA_DEPTH(DEPTH),
                  .SUM_WIDTH(DW + NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int exp_ptr  = 0;

   int unsigned wr_addr_q[$];
   int unsigned wr_din_q[$];
   int          wr_bad_we = 0;

   // Record every BRAM write cycle; ena and wea must always move together
   always @(negedge clk) begin
      if (bus.alpha_BRAM_ena || bus.alpha_BRAM_wea) begin
         wr_addr_q.push_back(bus.alpha_BRAM_addra);
         wr_din_q.push_back(int'(bus.alpha_BRAM_din));
         if (!(bus.alpha_BRAM_ena && bus.alpha_BRAM_wea)) wr_bad_we++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic start_vec(input string name, input int n_in, input int c[4], input int fill);
      @(negedge clk);
      chk({name, " idle before"}, bus.softmax_idle_o, 1);
      for (int k = 0; k < NN; k++) bus.coef_i[k] = DW'((k < 4) ? c[k] : fill);
      bus.num_of_nodes_i = (NW+1)'(n_in);
      bus.dmvm_ready_i   = 1'b1;
      @(negedge clk);
      bus.dmvm_ready_i   = 1'b0;
   endtask

   task automatic run_vec(input string name, input int n_in, input int c[4], input int fill,
                          input int ea[4], input int efill, input int drop_at);
      int nn;
      int cyc;
      int lat;
      nn = (n_in > NN) ? NN : n_in;
      wr_addr_q.delete();
      wr_din_q.delete();
      start_vec(name, n_in, c, fill);
      cyc = 1;
      lat = -1;
      while (cyc <= 4000) begin
         if (drop_at != 0 && cyc == drop_at) begin
            for (int k = 0; k < NN; k++) bus.coef_i[k] = 8'hFF;
            bus.num_of_nodes_i = 1;
            bus.dmvm_ready_i   = 1'b1;
         end else if (drop_at != 0 && cyc == drop_at + 1) begin
            bus.dmvm_ready_i   = 1'b0;
         end
         if (bus.softmax_ready_o) begin
            lat = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      bus.dmvm_ready_i = 1'b0;
      chk({name, " latency"}, lat, 2*nn + nn*(DW+2) + 1);
      chk({name, " write count"}, wr_din_q.size(), nn);
      for (int k = 0; k < nn && k < wr_din_q.size(); k++) begin
         chk($sformatf("%s alpha[%0d]", name, k), wr_din_q[k], (k < 4) ? ea[k] : efill);
         chk($sformatf("%s addr[%0d]", name, k), wr_addr_q[k], exp_ptr);
         exp_ptr = (exp_ptr + 1) % DEPTH;
      end
      @(negedge clk);
      chk({name, " ready pulse ends"}, bus.softmax_ready_o, 0);
      chk({name, " idle after"}, bus.softmax_idle_o, 1);
   endtask

   initial begin
      bus.dmvm_ready_i   = 1'b0;
      bus.num_of_nodes_i = '0;
      for (int k = 0; k < NN; k++) bus.coef_i[k] = '0;

      repeat (3) @(negedge clk);
      chk("reset idle",  bus.softmax_idle_o, 1);
      chk("reset ena",   bus.alpha_BRAM_ena, 0);
      chk("reset wea",   bus.alpha_BRAM_wea, 0);
      chk("reset addr",  bus.alpha_BRAM_addra, 0);
      chk("reset din",   bus.alpha_BRAM_din, 0);
      chk("reset ready", bus.softmax_ready_o, 0);
      chk("reset drop",  bus.drop_err_o, 0);
      rst_n = 1'b1;

      // single node: sum=255, q=256 saturates to 255
      run_vec("n1",        1, '{7, 0, 0, 0},     0, '{255, 0, 0, 0},   0, 0);
      // equal pair: 65280/510 = 128 each
      run_vec("eq2",       2, '{10, 10, 0, 0},   0, '{128, 128, 0, 0}, 0, 0);
      chk("drop clear before", bus.drop_err_o, 0);
      // e={255,63}, sum=318 -> 205, 50; addresses 3 then wrap to 0; stray pulse in DIV
      run_vec("wrap_drop", 2, '{40, 32, 0, 0},   0, '{205, 50, 0, 0},  0, 6);
      chk("drop set", bus.drop_err_o, 1);
      // d=25 for the zeros -> only the max keeps weight
      run_vec("dom4",      4, '{100, 0, 0, 0},   0, '{255, 0, 0, 0},   0, 0);
      // empty sub-graph: DONE after one cycle, no writes
      run_vec("n0",        0, '{9, 9, 9, 9},     9, '{0, 0, 0, 0},     0, 0);
      // max at index 1: e={15,255,63}, sum=333 -> 11, 196, 48
      run_vec("mid_max",   3, '{4, 20, 12, 0},   0, '{11, 196, 48, 0}, 0, 0);
      // count clamped to 168, all equal: 65280/42840 -> 1
      run_vec("clamp",   200, '{3, 3, 3, 3},     3, '{1, 1, 1, 1},     1, 0);
      chk("drop sticky", bus.drop_err_o, 1);

      // reset during DIV of node 1: only node 0 is written, pointer returns to 0
      wr_addr_q.delete();
      wr_din_q.delete();
      start_vec("rst", 2, '{10, 10, 0, 0}, 0);
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst-low ena",   bus.alpha_BRAM_ena, 0);
      chk("rst-low wea",   bus.alpha_BRAM_wea, 0);
      chk("rst-low addr",  bus.alpha_BRAM_addra, 0);
      chk("rst-low din",   bus.alpha_BRAM_din, 0);
      chk("rst-low ready", bus.softmax_ready_o, 0);
      chk("rst-low idle",  bus.softmax_idle_o, 1);
      chk("rst-low drop",  bus.drop_err_o, 0);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("rst write count", wr_din_q.size(), 1);
      if (wr_din_q.size() > 0) begin
         chk("rst write din",  wr_din_q[0], 128);
         chk("rst write addr", wr_addr_q[0], exp_ptr);
      end
      chk("rst idle after", bus.softmax_idle_o, 1);
      exp_ptr = 0;

      run_vec("post_rst",  1, '{7, 0, 0, 0},     0, '{255, 0, 0, 0},   0, 0);
      chk("ena==wea", wr_bad_we, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
